serial_nibble_loader: RTL and testbench
=======================================

SERIAL_NIBBLE_LOADER -- requirements
Module: serial_nibble_loader

Interface
REQ-001 Parameter PARITY_EN, default 1: 1 = each nibble is followed by one odd-parity bit; 0 = no parity bit.
REQ-002 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 Port clrb, input, 1: reset, asynchronous, active-low.
REQ-004 Port sin, input, 1: serial data bit, LSB first.
REQ-005 Port sin_valid, input, 1: sin is sampled this cycle.
REQ-006 Port frame, input, 1: qualifies a sampled bit as bit 0 of a new nibble.
REQ-007 Port out_ready, input, 1: downstream 4-bit register accepts the word this cycle.
REQ-008 Port out_data, output, 4: assembled nibble; feeds the d[3:0] input of the downstream 4-bit register.
REQ-009 Port out_valid, output, 1: out_data holds a valid nibble.
REQ-010 Port par_err, output, 1: one-cycle pulse when a nibble fails its parity check.
REQ-011 Port overrun, output, 1: sticky flag; a good nibble was dropped because the buffer was full.
REQ-012 Port busy, output, 1: high while the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and PARITY; it SHALL ignore cycles with sin_valid=0.
REQ-014 In IDLE, sin_valid=1 with frame=1 SHALL load sin as bit 0, set the bit count to 1 and enter SHIFT; sin_valid=1 with frame=0 SHALL be ignored.
REQ-015 In SHIFT, each sampled bit SHALL be stored at position count (1..3).
REQ-016 After bit 3 is sampled, the FSM SHALL enter PARITY if PARITY_EN=1; otherwise it SHALL push the nibble and return to IDLE.
REQ-017 In PARITY, the sampled bit SHALL make the XOR of the five bits equal to 1.
  - Pass: push the nibble, return to IDLE.
  - Fail: discard the nibble, pulse par_err for exactly one cycle, return to IDLE.
REQ-018 A sampled bit with frame=1 in SHIFT or PARITY SHALL abort the partial nibble without any error flag and restart as bit 0 (state SHIFT, count 1).
REQ-019 Completed nibbles SHALL enter a 2-entry FIFO; out_data/out_valid SHALL present the FIFO head.
REQ-020 A transfer SHALL occur when out_valid=1 and out_ready=1; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 When the FIFO is empty, out_valid SHALL assert on the cycle after the clock edge that samples the final data or parity bit (latency 1).
REQ-022 A push while the FIFO is full SHALL be accepted if a pop occurs in the same cycle; otherwise the nibble SHALL be dropped and overrun set.
REQ-023 A simultaneous push and pop on an empty FIFO SHALL NOT bypass the buffer; the pushed nibble appears next cycle.
REQ-024 FIFO pointers SHALL wrap modulo 2; the occupancy count SHALL range 0..2.
REQ-025 overrun SHALL clear only on reset.

Reset
REQ-026 clrb=0 SHALL immediately force:
  - FSM to IDLE, count to 0, shift register to 0;
  - FIFO to empty;
  - out_valid=0, out_data=0, par_err=0, overrun=0, busy=0.
REQ-027 Reset mid-nibble SHALL discard the partial nibble; the first sampled bit after release SHALL require frame=1.
REQ-028 Operation SHALL resume on the first rising clk edge after clrb returns to 1.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration, the constant NIBBLE_W=4 and the constant FIFO_DEPTH=2.
REQ-030 The FIFO SHALL be a sub-module named nibble_fifo; the FSM and shifter SHALL remain in the top module.

Verification
REQ-031 PARITY_EN=1; send 1,0,1,1 (LSB first) then parity 0; out_ready=1 -> out_valid pulses one cycle later with out_data=4'hD; par_err stays 0.
REQ-032 Same bits with parity 1 -> no out_valid; par_err high for exactly one cycle.
REQ-033 out_ready=0; send three good nibbles 4'h1, 4'h2, 4'h3 -> 4'h1 and 4'h2 are held, 4'h3 is dropped, overrun=1; then out_ready=1 -> 4'h1 then 4'h2 are delivered, overrun remains 1.
REQ-034 Send two bits, then a bit with frame=1, then complete nibble 4'hA -> only 4'hA is output; no par_err.
REQ-035 Assert clrb=0 in PARITY state with the FIFO holding one entry -> all outputs read 0 immediately; a later frame-aligned nibble is output correctly.
REQ-036 PARITY_EN=0; FIFO full and out_ready=1 while the fourth bit of a new nibble is sampled -> head popped, new nibble accepted, overrun stays 0.

Source files
------------

// File: rtl/serial_nibble_loader_pkg.sv
// Purpose : shared types and constants for the serial nibble loader.
// Latency : n/a (types, constants and a parity helper only).
// Backpressure: n/a.
package serial_nibble_loader_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int BIT_CNT_W  = $clog2(NIBBLE_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // Odd parity: nibble bits plus the parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [NIBBLE_W-1:0] nib,
                                         input logic                par_bit);
    return ^{nib, par_bit};
  endfunction

endpackage

// File: rtl/serial_nibble_loader_if.sv
// Purpose : bundles the serial input side and the nibble output side.
// Latency : n/a (wires only).
// Backpressure: out_ready from the downstream register gates out_valid transfers.
// Ports   : sin/sin_valid/frame (serial in), out_ready (downstream accept),
//           out_data/out_valid (FIFO head), par_err/overrun/busy (status).
interface serial_nibble_loader_if;
  import serial_nibble_loader_pkg::*;

  logic                sin;
  logic                sin_valid;
  logic                frame;
  logic                out_ready;
  logic [NIBBLE_W-1:0] out_data;
  logic                out_valid;
  logic                par_err;
  logic                overrun;
  logic                busy;

  // master: the environment driving bits in and draining nibbles out
  modport master (
    output sin, sin_valid, frame, out_ready,
    input  out_data, out_valid, par_err, overrun, busy
  );

  // slave: the loader itself
  modport slave (
    input  sin, sin_valid, frame, out_ready,
    output out_data, out_valid, par_err, overrun, busy
  );

endinterface

// File: rtl/serial_nibble_loader_fifo.sv
// Purpose : small FIFO holding completed nibbles; head is presented directly.
// Latency : a push is visible at the head on the cycle after the write edge (no bypass).
// Backpressure: push while full is accepted only if a pop happens the same cycle.
// Ports   : clk, clrb (async active-low), push_vld/push_dat, pop_rdy,
//           head_vld/head_dat, full.
module nibble_fifo
  import serial_nibble_loader_pkg::*;
(
  input  logic                clk,
  input  logic                clrb,
  input  logic                push_vld,
  input  logic [NIBBLE_W-1:0] push_dat,
  input  logic                pop_rdy,
  output logic                head_vld,
  output logic [NIBBLE_W-1:0] head_dat,
  output logic                full
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NIBBLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [NIBBLE_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                pop;
  logic                push_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_vld = (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop      = pop_rdy && head_vld;
  // A pop frees the slot the full-case push needs in the same cycle.
  assign push_ok  = push_vld && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/serial_nibble_loader.sv
// Purpose : assembles LSB-first serial bits into nibbles (optional odd parity) into a 2-deep FIFO.
// Latency : out_valid rises the cycle after the edge sampling the last data/parity bit (FIFO empty).
// Backpressure: out_ready pops the FIFO head; a good nibble arriving while full with no pop is dropped and overrun latches.
// Ports   : clk, clrb (async active-low), bus (slave modport of serial_nibble_loader_if).
module serial_nibble_loader
  import serial_nibble_loader_pkg::*;
#(
  parameter bit PARITY_EN = 1'b1
)
(
  input  logic                  clk,
  input  logic                  clrb,
  serial_nibble_loader_if.slave bus
);

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [NIBBLE_W-1:0]  shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 overrun_q, overrun_d;

  logic                 push_vld;
  logic [NIBBLE_W-1:0]  push_dat;
  logic                 head_vld;
  logic [NIBBLE_W-1:0]  head_dat;
  logic                 fifo_full;
  logic                 pop;

  assign pop = head_vld && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_err_d = 1'b0;
    push_vld  = 1'b0;
    push_dat  = shift_q;
    if (bus.sin_valid) begin
      if (bus.frame) begin
        // A framed bit always starts a fresh nibble, silently abandoning any partial one.
        shift_d    = '0;
        shift_d[0] = bus.sin;
        cnt_d      = BIT_CNT_W'(1);
        state_d    = ST_SHIFT;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            shift_d[cnt_q] = bus.sin;
            if (cnt_q == BIT_CNT_W'(NIBBLE_W - 1)) begin
              cnt_d = '0;
              if (PARITY_EN) begin
                state_d = ST_PARITY;
              end else begin
                state_d  = ST_IDLE;
                push_vld = 1'b1;
                push_dat = shift_d;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_PARITY: begin
            state_d = ST_IDLE;
            if (odd_parity_ok(shift_q, bus.sin)) begin
              push_vld = 1'b1;
            end else begin
              par_err_d = 1'b1;
            end
          end
          default: begin
            // IDLE: unframed bits are not the start of a nibble
          end
        endcase
      end
    end
    overrun_d = overrun_q || (push_vld && fifo_full && !pop);
  end

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      overrun_q <= overrun_d;
    end
  end

  nibble_fifo u_fifo (
    .clk      (clk),
    .clrb     (clrb),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (bus.out_ready),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .full     (fifo_full)
  );

  assign bus.out_data  = head_dat;
  assign bus.out_valid = head_vld;
  assign bus.par_err   = par_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_nibble_loader.sv
// Directed bench: one loader with parity enabled (u_dut1) and one without (u_dut0).
module tb_serial_nibble_loader;

  logic clk;
  logic clrb;
  int   total;
  int   passed;

  serial_nibble_loader_if bus1 ();
  serial_nibble_loader_if bus0 ();

  serial_nibble_loader #(.PARITY_EN(1'b1)) u_dut1 (.clk(clk), .clrb(clrb), .bus(bus1.slave));
  serial_nibble_loader #(.PARITY_EN(1'b0)) u_dut0 (.clk(clk), .clrb(clrb), .bus(bus0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle on the parity-enabled loader, then sit 1 time unit past the edge.
  task automatic step1(input logic v, input logic s, input logic f);
    bus1.sin_valid = v;
    bus1.sin       = s;
    bus1.frame     = f;
    @(posedge clk);
    #1;
    bus1.sin_valid = 1'b0;
    bus1.frame     = 1'b0;
  endtask

  task automatic step0(input logic v, input logic s, input logic f);
    bus0.sin_valid = v;
    bus0.sin       = s;
    bus0.frame     = f;
    @(posedge clk);
    #1;
    bus0.sin_valid = 1'b0;
    bus0.frame     = 1'b0;
  endtask

  task automatic send_nib1(input logic [3:0] n, input logic p);
    step1(1'b1, n[0], 1'b1);
    step1(1'b1, n[1], 1'b0);
    step1(1'b1, n[2], 1'b0);
    step1(1'b1, n[3], 1'b0);
    step1(1'b1, p,    1'b0);
  endtask

  task automatic send_nib0(input logic [3:0] n);
    step0(1'b1, n[0], 1'b1);
    step0(1'b1, n[1], 1'b0);
    step0(1'b1, n[2], 1'b0);
    step0(1'b1, n[3], 1'b0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    clrb   = 1'b1;
    bus1.sin = 1'b0; bus1.sin_valid = 1'b0; bus1.frame = 1'b0; bus1.out_ready = 1'b0;
    bus0.sin = 1'b0; bus0.sin_valid = 1'b0; bus0.frame = 1'b0; bus0.out_ready = 1'b0;

    // Reset state
    #2 clrb = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", {3'b0, bus1.out_valid}, 4'h0);
    check("rst_out_data",  bus1.out_data,          4'h0);
    check("rst_par_err",   {3'b0, bus1.par_err},   4'h0);
    check("rst_overrun",   {3'b0, bus1.overrun},   4'h0);
    check("rst_busy",      {3'b0, bus1.busy},      4'h0);
    check("rst_busy0",     {3'b0, bus0.busy},      4'h0);
    #2 clrb = 1'b1;

    // Good nibble D (1,0,1,1) with parity 0
    bus1.out_ready = 1'b1;
    step1(1'b0, 1'b1, 1'b0);
    step1(1'b1, 1'b0, 1'b0);
    check("idle_unframed_busy", {3'b0, bus1.busy}, 4'h0);
    step1(1'b1, 1'b1, 1'b1);
    check("a_busy", {3'b0, bus1.busy}, 4'h1);
    step1(1'b1, 1'b0, 1'b0);
    step1(1'b0, 1'b1, 1'b0);
    step1(1'b1, 1'b1, 1'b0);
    step1(1'b1, 1'b1, 1'b0);
    check("a_no_early_valid", {3'b0, bus1.out_valid}, 4'h0);
    step1(1'b1, 1'b0, 1'b0);
    check("a_out_valid", {3'b0, bus1.out_valid}, 4'h1);
    check("a_out_data",  bus1.out_data,          4'hD);
    check("a_par_err",   {3'b0, bus1.par_err},   4'h0);
    check("a_busy_done", {3'b0, bus1.busy},      4'h0);
    step1(1'b0, 1'b0, 1'b0);
    check("a_valid_pulse_end", {3'b0, bus1.out_valid}, 4'h0);

    // Same bits, bad parity 1
    send_nib1(4'hD, 1'b1);
    check("b_out_valid", {3'b0, bus1.out_valid}, 4'h0);
    check("b_par_err",   {3'b0, bus1.par_err},   4'h1);
    step1(1'b0, 1'b0, 1'b0);
    check("b_par_err_end", {3'b0, bus1.par_err}, 4'h0);

    // Overrun: 1, 2 held, 3 dropped
    bus1.out_ready = 1'b0;
    send_nib1(4'h1, 1'b0);
    send_nib1(4'h2, 1'b0);
    check("c_hold_data",  bus1.out_data,        4'h1);
    check("c_no_overrun", {3'b0, bus1.overrun}, 4'h0);
    send_nib1(4'h3, 1'b1);
    check("c_overrun",    {3'b0, bus1.overrun}, 4'h1);
    check("c_head_data",  bus1.out_data,        4'h1);
    check("c_head_valid", {3'b0, bus1.out_valid}, 4'h1);
    bus1.out_ready = 1'b1;
    step1(1'b0, 1'b0, 1'b0);
    check("c_second_data",  bus1.out_data,          4'h2);
    check("c_second_valid", {3'b0, bus1.out_valid}, 4'h1);
    step1(1'b0, 1'b0, 1'b0);
    check("c_drained",       {3'b0, bus1.out_valid}, 4'h0);
    check("c_overrun_stick", {3'b0, bus1.overrun},   4'h1);

    // Abort by reframe, then nibble A (0,1,0,1) parity 1
    step1(1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b1, 1'b0);
    check("d_busy_partial", {3'b0, bus1.busy}, 4'h1);
    send_nib1(4'hA, 1'b1);
    check("d_out_valid", {3'b0, bus1.out_valid}, 4'h1);
    check("d_out_data",  bus1.out_data,          4'hA);
    check("d_par_err",   {3'b0, bus1.par_err},   4'h0);
    step1(1'b0, 1'b0, 1'b0);
    check("d_only_one", {3'b0, bus1.out_valid}, 4'h0);

    // Reset while in PARITY with one FIFO entry
    bus1.out_ready = 1'b0;
    send_nib1(4'h5, 1'b1);
    step1(1'b1, 1'b0, 1'b1);
    step1(1'b1, 1'b1, 1'b0);
    step1(1'b1, 1'b1, 1'b0);
    step1(1'b1, 1'b0, 1'b0);
    check("e_busy_parity",  {3'b0, bus1.busy},      4'h1);
    check("e_valid_before", {3'b0, bus1.out_valid}, 4'h1);
    check("e_data_before",  bus1.out_data,          4'h5);
    #2 clrb = 1'b0;
    #1;
    check("e_rst_valid",   {3'b0, bus1.out_valid}, 4'h0);
    check("e_rst_data",    bus1.out_data,          4'h0);
    check("e_rst_busy",    {3'b0, bus1.busy},      4'h0);
    check("e_rst_overrun", {3'b0, bus1.overrun},   4'h0);
    check("e_rst_par_err", {3'b0, bus1.par_err},   4'h0);
    @(posedge clk);
    #2 clrb = 1'b1;
    step1(1'b1, 1'b1, 1'b0);
    check("e_unframed_ignored", {3'b0, bus1.busy}, 4'h0);
    bus1.out_ready = 1'b1;
    send_nib1(4'h9, 1'b1);
    check("e_after_valid", {3'b0, bus1.out_valid}, 4'h1);
    check("e_after_data",  bus1.out_data,          4'h9);

    // No-parity loader: full FIFO, pop and push on the same edge
    bus0.out_ready = 1'b0;
    send_nib0(4'h7);
    check("f_first_valid", {3'b0, bus0.out_valid}, 4'h1);
    check("f_first_data",  bus0.out_data,          4'h7);
    send_nib0(4'hC);
    step0(1'b1, 1'b0, 1'b1);
    step0(1'b1, 1'b1, 1'b0);
    step0(1'b1, 1'b1, 1'b0);
    check("f_busy",      {3'b0, bus0.busy},   4'h1);
    check("f_head_held", bus0.out_data,       4'h7);
    bus0.out_ready = 1'b1;
    step0(1'b1, 1'b1, 1'b0);
    check("f_popped_head", bus0.out_data,          4'hC);
    check("f_overrun_0",   {3'b0, bus0.overrun},   4'h0);
    check("f_valid",       {3'b0, bus0.out_valid}, 4'h1);
    step0(1'b0, 1'b0, 1'b0);
    check("f_new_nibble", bus0.out_data, 4'hE);
    step0(1'b0, 1'b0, 1'b0);
    check("f_drained",       {3'b0, bus0.out_valid}, 4'h0);
    check("f_overrun_final", {3'b0, bus0.overrun},   4'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
